pl_calc_sequencer: RTL and testbench

Backend controller for the PS-PL interface: it answers the frontend's `sync`/`ack` CALC handshake and sequences N_UNITS compute units that share one configuration bus. On each CALC request it slices `buffer_in` into per-unit configuration words and runs each unit in turn with a start/done handshake and timeout. It packs the per-unit results into `buffer_out` and completes the handshake. It sits between the PS-PL frontend and the custom measurement units in PL.

---
 rtl/pl_calc_sequencer_if.sv | 36 +++
 rtl/pl_calc_sequencer.sv | 157 +++++++++++++++
 tb/tb_pl_calc_sequencer.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pl_calc_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : pl_calc_sequencer_if
// Brief    : CALC handshake, config/result buffers and compute-unit bus.
// Revision : 1.0
// ============================================================================
// master = frontend plus compute units (drive sync/buffer_in/unit_done/result);
// slave  = the sequencer itself.
interface pl_calc_sequencer_if #(
  parameter int N_UNITS          = 4,
  parameter int UNIT_CFG_WIDTH   = 4,
  parameter int UNIT_RES_WIDTH   = 4,
  parameter int BUFFER_IN_WIDTH  = 16,
  parameter int BUFFER_OUT_WIDTH = 16
);
  logic                               sync;
  logic                               ack;
  logic [BUFFER_IN_WIDTH-1:0]         buffer_in;
  logic [BUFFER_OUT_WIDTH-1:0]        buffer_out;
  logic [N_UNITS-1:0]                 unit_start;
  logic [UNIT_CFG_WIDTH-1:0]          unit_cfg;
  logic [N_UNITS-1:0]                 unit_done;
  logic [N_UNITS*UNIT_RES_WIDTH-1:0]  unit_result;
  logic [N_UNITS-1:0]                 unit_timeout;

  modport master (
    output sync, buffer_in, unit_done, unit_result,
    input  ack, buffer_out, unit_start, unit_cfg, unit_timeout
  );

  modport slave (
    input  sync, buffer_in, unit_done, unit_result,
    output ack, buffer_out, unit_start, unit_cfg, unit_timeout
  );
endinterface
`default_nettype wire

// File: rtl/pl_calc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pl_calc_sequencer
// Brief    : Runs N_UNITS compute units in turn for each CALC request.
// Revision : 1.0
// ============================================================================
module pl_calc_sequencer #(
  parameter int N_UNITS          = 4,
  parameter int UNIT_CFG_WIDTH   = 4,
  parameter int UNIT_RES_WIDTH   = 4,
  parameter int BUFFER_IN_WIDTH  = 16,
  parameter int BUFFER_OUT_WIDTH = 16,
  parameter int TIMEOUT          = 255
) (
  input  logic                 clock,
  input  logic                 resetn,
  pl_calc_sequencer_if.slave   bus
);

  localparam int                IDX_W       = (N_UNITS > 1) ? $clog2(N_UNITS) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX    = IDX_W'(N_UNITS - 1);
  localparam logic [7:0]        TIMEOUT_CNT = 8'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_DISPATCH = 3'd1,
    S_WAIT     = 3'd2,
    S_NEXT     = 3'd3,
    S_ACK      = 3'd4
  } state_t;

  state_t                        state, state_nxt;
  logic [IDX_W-1:0]              idx, idx_nxt;
  logic [7:0]                    timer, timer_nxt;
  logic [BUFFER_IN_WIDTH-1:0]    cfg_reg, cfg_nxt;
  logic [BUFFER_OUT_WIDTH-1:0]   res_reg, res_nxt;
  logic                          ack_reg, ack_nxt;
  logic [BUFFER_OUT_WIDTH-1:0]   bout_reg, bout_nxt;
  logic [N_UNITS-1:0]            start_reg, start_nxt;
  logic [UNIT_CFG_WIDTH-1:0]     ucfg_reg, ucfg_nxt;
  logic [N_UNITS-1:0]            tmo_reg, tmo_nxt;

  logic [31:0]                   cfg_lsb;
  logic [31:0]                   res_lsb;
  logic [UNIT_CFG_WIDTH-1:0]     cur_cfg;

  assign cfg_lsb = 32'(idx) * UNIT_CFG_WIDTH;
  assign res_lsb = 32'(idx) * UNIT_RES_WIDTH;
  assign cur_cfg = cfg_reg[cfg_lsb +: UNIT_CFG_WIDTH];

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state     <= S_IDLE;
      idx       <= '0;
      timer     <= '0;
      cfg_reg   <= '0;
      res_reg   <= '0;
      ack_reg   <= 1'b0;
      bout_reg  <= '0;
      start_reg <= '0;
      ucfg_reg  <= '0;
      tmo_reg   <= '0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      timer     <= timer_nxt;
      cfg_reg   <= cfg_nxt;
      res_reg   <= res_nxt;
      ack_reg   <= ack_nxt;
      bout_reg  <= bout_nxt;
      start_reg <= start_nxt;
      ucfg_reg  <= ucfg_nxt;
      tmo_reg   <= tmo_nxt;
    end
  end

  // Dropping sync mid-sequence aborts before any per-state action.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    timer_nxt = timer;
    cfg_nxt   = cfg_reg;
    res_nxt   = res_reg;
    ack_nxt   = ack_reg;
    bout_nxt  = bout_reg;
    start_nxt = '0;
    ucfg_nxt  = ucfg_reg;
    tmo_nxt   = tmo_reg;

    case (state)
      S_IDLE: begin
        ack_nxt = 1'b0;
        if (bus.sync) begin
          cfg_nxt   = bus.buffer_in;
          res_nxt   = '0;
          tmo_nxt   = '0;
          idx_nxt   = '0;
          state_nxt = S_DISPATCH;
        end
      end
      S_DISPATCH: begin
        if (!bus.sync) begin
          state_nxt = S_IDLE;
        end else if (cur_cfg == '0) begin
          res_nxt[res_lsb +: UNIT_RES_WIDTH] = '0;
          state_nxt = S_NEXT;
        end else begin
          ucfg_nxt       = cur_cfg;
          start_nxt[idx] = 1'b1;
          timer_nxt      = '0;
          state_nxt      = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!bus.sync) begin
          state_nxt = S_IDLE;
        end else if (bus.unit_done[idx]) begin
          res_nxt[res_lsb +: UNIT_RES_WIDTH] = bus.unit_result[res_lsb +: UNIT_RES_WIDTH];
          state_nxt = S_NEXT;
        end else if (timer == TIMEOUT_CNT) begin
          res_nxt[res_lsb +: UNIT_RES_WIDTH] = '1;
          tmo_nxt[idx] = 1'b1;
          state_nxt    = S_NEXT;
        end else begin
          timer_nxt = timer + 8'd1;
        end
      end
      S_NEXT: begin
        if (!bus.sync) begin
          state_nxt = S_IDLE;
        end else if (idx == LAST_IDX) begin
          bout_nxt  = res_reg;
          ack_nxt   = 1'b1;
          state_nxt = S_ACK;
        end else begin
          idx_nxt   = idx + 1'b1;
          state_nxt = S_DISPATCH;
        end
      end
      S_ACK: begin
        if (!bus.sync) begin
          ack_nxt   = 1'b0;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign bus.ack          = ack_reg;
  assign bus.buffer_out   = bout_reg;
  assign bus.unit_start   = start_reg;
  assign bus.unit_cfg     = ucfg_reg;
  assign bus.unit_timeout = tmo_reg;

endmodule
`default_nettype wire

// File: tb/tb_pl_calc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pl_calc_sequencer
// Brief    : Vector table plus scoreboard bench for pl_calc_sequencer.
// Revision : 1.0
// ============================================================================
module tb_pl_calc_sequencer;

  localparam int N   = 4;
  localparam int CW  = 4;
  localparam int RW  = 4;
  localparam int BW  = 16;
  localparam int TMO = 5;

  typedef struct {
    logic [15:0]      bin;
    logic [3:0][7:0]  dly;   // per-unit done delay after start; 0 = never
    logic [15:0]      res;
    logic [15:0]      bout;
    logic [3:0]       tmo;
    int               lat;
  } vec_t;

  typedef struct {
    logic [15:0] bout;
    logic [3:0]  tmo;
    int          lat;
  } exp_t;

  typedef struct {
    int          idx;
    logic [3:0]  cfg;
  } start_t;

  logic clock = 1'b0;
  logic resetn = 1'b0;

  pl_calc_sequencer_if #(.N_UNITS(N), .UNIT_CFG_WIDTH(CW), .UNIT_RES_WIDTH(RW),
                         .BUFFER_IN_WIDTH(BW), .BUFFER_OUT_WIDTH(BW)) bus ();

  pl_calc_sequencer #(.N_UNITS(N), .UNIT_CFG_WIDTH(CW), .UNIT_RES_WIDTH(RW),
                      .BUFFER_IN_WIDTH(BW), .BUFFER_OUT_WIDTH(BW), .TIMEOUT(TMO)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  int               n_cmp = 0;
  int               n_err = 0;
  int               cyc = 0;
  int               start_cyc = 0;
  logic [3:0][7:0]  dly = '0;
  logic [3:0]       stray = '0;
  exp_t             exp_q[$];
  start_t           cfg_q[$];
  vec_t             vecs[6];

  initial forever #5 clock = ~clock;
  initial forever begin @(posedge clock); cyc++; end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Unit model: done pulses 'dly' cycles after the start pulse, plus stray bits.
  initial begin
    int cnt[N];
    logic [3:0] done_v;
    for (int i = 0; i < N; i++) cnt[i] = 0;
    bus.unit_done = '0;
    forever begin
      @(negedge clock);
      done_v = stray;
      for (int i = 0; i < N; i++) begin
        if (bus.unit_start[i]) cnt[i] = int'(dly[i]);
        if (cnt[i] == 1) done_v[i] = 1'b1;
        if (cnt[i] > 0) cnt[i]--;
      end
      bus.unit_done = done_v;
    end
  end

  initial begin
    start_t s;
    forever begin
      @(negedge clock);
      if (bus.unit_start != '0) begin
        if (cfg_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL start_unexpected: unit_start=%b, none expected", bus.unit_start);
        end else begin
          s = cfg_q.pop_front();
          chk("start_sel", 32'(bus.unit_start), 32'(1) << s.idx);
          chk("unit_cfg", 32'(bus.unit_cfg), 32'(s.cfg));
        end
      end
    end
  end

  initial begin
    logic ack_prev;
    exp_t e;
    ack_prev = 1'b0;
    forever begin
      @(negedge clock);
      if (bus.ack && !ack_prev) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL ack_unexpected: ack=1, none expected");
        end else begin
          e = exp_q.pop_front();
          chk("buffer_out", 32'(bus.buffer_out), 32'(e.bout));
          chk("unit_timeout", 32'(bus.unit_timeout), 32'(e.tmo));
          chk("ack_latency", 32'(cyc - start_cyc - 1), 32'(e.lat));
        end
      end
      ack_prev = bus.ack;
    end
  end

  task automatic push_cfg(input logic [15:0] b, input int n_max);
    int k = 0;
    logic [3:0] s;
    for (int i = 0; i < N; i++) begin
      s = b[i*CW +: CW];
      if (s != 4'd0 && k < n_max) begin
        cfg_q.push_back('{idx: i, cfg: s});
        k++;
      end
    end
  endtask

  task automatic start_calc(input vec_t v, input int n_starts, input bit expect_ack);
    @(negedge clock);
    bus.buffer_in   = v.bin;
    bus.unit_result = v.res;
    dly             = v.dly;
    push_cfg(v.bin, n_starts);
    if (expect_ack) exp_q.push_back('{bout: v.bout, tmo: v.tmo, lat: v.lat});
    bus.sync  = 1'b1;
    start_cyc = cyc;
  endtask

  task automatic finish_calc(input vec_t v);
    int k = 0;
    while (!bus.ack && k < 200) begin
      @(negedge clock);
      k++;
    end
    if (!bus.ack) begin
      n_cmp++;
      n_err++;
      $display("FAIL ack_wait: ack=0 after %0d cycles, required 1", k);
      exp_q.delete();
      cfg_q.delete();
    end
    bus.sync = 1'b0;
    @(negedge clock);
    chk("ack_fall", 32'(bus.ack), 32'd0);
    chk("bout_hold", 32'(bus.buffer_out), 32'(v.bout));
    @(negedge clock);
  endtask

  task automatic wait_start(input int u);
    int k = 0;
    while (!bus.unit_start[u] && k < 100) begin
      @(negedge clock);
      k++;
    end
    if (!bus.unit_start[u]) begin
      n_cmp++;
      n_err++;
      $display("FAIL start_wait: unit_start[%0d]=0 after %0d cycles, required 1", u, k);
    end
  endtask

  initial begin
    vec_t v;
    logic seen_ack;

    vecs[0] = '{bin: 16'h0000, dly: {8'd1, 8'd1, 8'd1, 8'd1}, res: 16'hDCBA,
                bout: 16'h0000, tmo: 4'b0000, lat: 8};
    vecs[1] = '{bin: 16'h4321, dly: {8'd3, 8'd3, 8'd3, 8'd3}, res: 16'hDCBA,
                bout: 16'hDCBA, tmo: 4'b0000, lat: 20};
    vecs[2] = '{bin: 16'h0505, dly: {8'd0, 8'd0, 8'd0, 8'd1}, res: 16'h1234,
                bout: 16'h0F04, tmo: 4'b0100, lat: 15};
    vecs[3] = '{bin: 16'h0070, dly: {8'd0, 8'd0, 8'd6, 8'd0}, res: 16'h5A5A,
                bout: 16'h0050, tmo: 4'b0000, lat: 14};
    vecs[4] = '{bin: 16'h0070, dly: {8'd0, 8'd0, 8'd7, 8'd0}, res: 16'h5A5A,
                bout: 16'h00F0, tmo: 4'b0010, lat: 14};
    vecs[5] = '{bin: 16'h9F1C, dly: {8'd0, 8'd4, 8'd1, 8'd2}, res: 16'h3C7E,
                bout: 16'hFC7E, tmo: 4'b1000, lat: 21};

    bus.sync        = 1'b0;
    bus.buffer_in   = '0;
    bus.unit_result = '0;
    repeat (3) @(negedge clock);
    chk("rst_ack", 32'(bus.ack), 32'd0);
    chk("rst_bout", 32'(bus.buffer_out), 32'd0);
    chk("rst_start", 32'(bus.unit_start), 32'd0);
    chk("rst_cfg", 32'(bus.unit_cfg), 32'd0);
    chk("rst_tmo", 32'(bus.unit_timeout), 32'd0);
    resetn = 1'b1;
    @(negedge clock);

    for (int i = 0; i < 6; i++) begin
      start_calc(vecs[i], N, 1'b1);
      finish_calc(vecs[i]);
    end

    // Done exactly on the timeout edge, with a stray done from unit 3 meanwhile.
    start_calc(vecs[3], N, 1'b1);
    wait_start(1);
    repeat (2) @(negedge clock);
    stray = 4'b1000;
    repeat (2) @(negedge clock);
    stray = 4'b0000;
    finish_calc(vecs[3]);

    // Abort during unit 2 WAIT; unit 0 times out first, unit 1 finishes.
    v = '{bin: 16'h4321, dly: {8'd1, 8'd0, 8'd1, 8'd0}, res: 16'h7777,
          bout: 16'h0050, tmo: 4'b0001, lat: 0};
    start_calc(v, 3, 1'b0);
    wait_start(2);
    repeat (2) @(negedge clock);
    bus.sync = 1'b0;
    seen_ack = 1'b0;
    repeat (10) begin
      @(negedge clock);
      if (bus.ack) seen_ack = 1'b1;
    end
    chk("abort_no_ack", 32'(seen_ack), 32'd0);
    chk("abort_bout", 32'(bus.buffer_out), 32'(v.bout));
    chk("abort_tmo", 32'(bus.unit_timeout), 32'(v.tmo));
    chk("abort_starts", 32'(cfg_q.size()), 32'd0);
    start_calc(vecs[1], N, 1'b1);
    finish_calc(vecs[1]);

    // Reset pulse while unit 0 is waiting.
    v = '{bin: 16'h4321, dly: {8'd0, 8'd0, 8'd0, 8'd0}, res: 16'h0000,
          bout: 16'h0000, tmo: 4'b0000, lat: 0};
    start_calc(v, 1, 1'b0);
    wait_start(0);
    repeat (2) @(negedge clock);
    resetn   = 1'b0;
    bus.sync = 1'b0;
    @(negedge clock);
    resetn = 1'b1;
    chk("mrst_ack", 32'(bus.ack), 32'd0);
    chk("mrst_bout", 32'(bus.buffer_out), 32'd0);
    chk("mrst_start", 32'(bus.unit_start), 32'd0);
    chk("mrst_cfg", 32'(bus.unit_cfg), 32'd0);
    chk("mrst_tmo", 32'(bus.unit_timeout), 32'd0);
    repeat (10) @(negedge clock);
    chk("mrst_starts", 32'(cfg_q.size()), 32'd0);
    start_calc(vecs[5], N, 1'b1);
    finish_calc(vecs[5]);

    repeat (2) @(negedge clock);
    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
    chk("cfg_q_empty", 32'(cfg_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1);
  end

endmodule
`default_nettype wire
